ifetch_seq: RTL and testbench
=============================

# ifetch_seq

Instruction fetch sequencer for the LEGv8 core. It drives the byte-wide instruction memory one byte address per cycle and assembles four consecutive bytes into a 32-bit little-endian instruction. It presents that instruction to decode over a valid/ready handshake. It also owns the fetch PC, including sequential increment, branch/redirect load, and fault detection for misaligned or out-of-range addresses.

## Interface
Parameters:
- `MEM_BYTES`, default 32: instruction memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- `RESET_PC`, default 0: fetch PC after reset; must be 4-byte aligned.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `PC_IN`  in  64  redirect target byte address.
- `PC_LOAD`  in  1  redirect strobe; one-cycle pulse.
- `MEM_ADDR`  out  64  byte address to instruction memory.
- `MEM_DATA`  in  8  byte read from memory; combinational, same cycle as `MEM_ADDR`.
- `INSTRUCTION`  out  32  assembled instruction.
- `INST_PC`  out  64  byte address of `INSTRUCTION`.
- `INST_VALID`  out  1  `INSTRUCTION`/`INST_PC` valid.
- `INST_READY`  in  1  decode accepts.
- `FAULT`  out  1  fetch halted on a bad address.

## Operation
- State: `pc` (64), `cnt` (2 bits, byte index), `asm` (32), and FSM `{FETCH, HOLD, FLT}`.
- Reset values: `pc=RESET_PC`, `cnt=0`, `state=FETCH`, `INSTRUCTION=0`, `INST_PC=0`, `INST_VALID=0`, `FAULT=0`.
- Combinational memory address: `MEM_ADDR = pc + cnt` in FETCH. `MEM_ADDR = pc` in HOLD and FLT.
- **FETCH**
  - Each cycle, `asm[8*cnt +: 8] <= MEM_DATA` and `cnt` increments.
  - On `cnt==3`: `INSTRUCTION <=` the completed word (byte at `pc` in [7:0], byte at `pc+3` in [31:24]), `INST_PC <= pc`, `INST_VALID <= 1`, `cnt <= 0`, go to HOLD.
- **HOLD**
  - Outputs are stable while `INST_VALID && !INST_READY`.
  - On `INST_VALID && INST_READY`: `pc <= pc+4`, `INST_VALID <= 0`, go to FETCH.
- **Range check**
  - Applies on entry to FETCH with `cnt==0`.
  - If `pc+3 >= MEM_BYTES`, go to FLT instead of fetching.
  - Computed in full 64-bit unsigned arithmetic. No wrap: `pc` near 2^64 faults.
- **FLT**
  - `FAULT=1`, `INST_VALID=0`.
  - Exited only by `RST` or a `PC_LOAD`.
- **Redirect (`PC_LOAD`)** has priority over everything except `RST`, in every state.
  - If `PC_IN[1:0]!=0`, go to FLT with `FAULT <= 1`.
  - Otherwise `pc <= PC_IN`, `cnt <= 0`, `FAULT <= 0`, go to FETCH.
  - `INST_VALID <= 0` next cycle. A partially assembled word is discarded.
- **Redirect during a handshake:** if `PC_LOAD` coincides with `INST_VALID && INST_READY`, the handshake completes (decode has taken the word) and the next PC is `PC_IN`, not `pc+4`.
- **Reset mid-fetch:** all state returns to reset values on that edge. Fetch restarts from `RESET_PC`.

## Timing
- Fetch latency: entering FETCH with `cnt==0` at edge N gives `INST_VALID` high after edge N+4.
- Throughput: 5 cycles per instruction with `INST_READY` held high (4 FETCH cycles + 1 HOLD cycle).
- `MEM_DATA` must settle within the cycle in which `MEM_ADDR` is driven. No registered memory read.
- `FAULT` rises one cycle after the offending `PC_LOAD`, or one cycle after entering FETCH with an out-of-range `pc`.
- Outputs are registered except `MEM_ADDR`.

## Structure
- Shared package `legv8_pkg`:
  - `fetch_state_t` enum `{FETCH, HOLD, FLT}`.
  - Constant `INST_BYTES = 4`.
  - Constant `PC_W = 64`.
- Single module with no sub-modules. Byte assembly is an in-module indexed write.
- The top level instantiates `ifetch_seq` next to the instruction memory. `MEM_ADDR` feeds the memory address and the memory byte output feeds `MEM_DATA`.

## Test plan
- **Reset and first fetch:** memory bytes 0..3 = 78,56,34,12; deassert `RST` -> after 4 edges `INST_VALID=1`, `INSTRUCTION=0x12345678`, `INST_PC=0`.
- **Backpressure then streaming:**
  - Hold `INST_READY=0` for 3 cycles -> outputs unchanged, `MEM_ADDR=0`.
  - Raise `INST_READY` -> second word `INST_PC=4` appears 5 cycles after the first handshake.
- **Redirect mid-fetch:** `PC_LOAD` with `PC_IN=0x10` at `cnt==2` -> no `INST_VALID` for the partial word; 4 cycles later `INST_PC=0x10` with the bytes from addresses 16..19.
- **Misaligned redirect:** `PC_LOAD` with `PC_IN=0x6` -> `FAULT=1` next cycle and `INST_VALID` stays 0; then `PC_LOAD` with `PC_IN=0x8` -> `FAULT=0` and a fetch from 8.
- **End of memory:** `PC_IN=28` -> instruction from bytes 28..31 delivered; after its handshake `FAULT=1` and no further valid.
- **Reset mid-operation:** assert `RST` in HOLD with `INST_VALID=1` -> next cycle `INST_VALID=0`, `FAULT=0`, `MEM_ADDR=RESET_PC`.
- **Simultaneous handshake and redirect:** `PC_LOAD` (`PC_IN=0x14`) coincides with the handshake -> next `INST_PC=0x14`, not `pc+4`.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 core definitions: fetch FSM encoding and fetch/PC widths.
package legv8_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLT   = 2'd2
  } fetch_state_t;

  localparam int INST_BYTES = 4;
  localparam int PC_W       = 64;

endpackage

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: reads four bytes of a byte-wide memory, one per
// cycle, into a little-endian word and offers it to decode over valid/ready.
module ifetch_seq
  import legv8_pkg::*;
#(
  parameter int unsigned     MEM_BYTES = 32,
  parameter logic [PC_W-1:0] RESET_PC  = 64'd0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] PC_IN,
  input  logic            PC_LOAD,
  output logic [PC_W-1:0] MEM_ADDR,
  input  logic [7:0]      MEM_DATA,
  output logic [31:0]     INSTRUCTION,
  output logic [PC_W-1:0] INST_PC,
  output logic            INST_VALID,
  input  logic            INST_READY,
  output logic            FAULT
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     instruction_q, instruction_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fault_q, fault_d;

  // One extra bit so a pc near 2^64 cannot wrap back into range.
  logic [PC_W:0]   last_byte_s;
  logic            out_of_range_s;

  assign last_byte_s    = {1'b0, pc_q} + 65'd3;
  assign out_of_range_s = (last_byte_s >= 65'(MEM_BYTES));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      cnt_q         <= 2'd0;
      asm_q         <= 32'd0;
      instruction_q <= 32'd0;
      inst_pc_q     <= 64'd0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      asm_q         <= asm_d;
      instruction_q <= instruction_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    instruction_d = instruction_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    fault_d       = fault_q;
    // A redirect wins in every state; any partial word is simply dropped.
    if (PC_LOAD) begin
      inst_valid_d = 1'b0;
      cnt_d        = 2'd0;
      if (PC_IN[1:0] != 2'b00) begin
        state_d = FLT;
        fault_d = 1'b1;
      end else begin
        state_d = FETCH;
        pc_d    = PC_IN;
        fault_d = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if ((cnt_q == 2'd0) && out_of_range_s) begin
            state_d      = FLT;
            fault_d      = 1'b1;
            inst_valid_d = 1'b0;
          end else begin
            asm_d[{cnt_q, 3'b000} +: 8] = MEM_DATA;
            cnt_d                       = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              instruction_d = asm_d;
              inst_pc_d     = pc_q;
              inst_valid_d  = 1'b1;
              state_d       = HOLD;
            end else begin
              state_d = FETCH;
            end
          end
        end
        HOLD: begin
          if (inst_valid_q && INST_READY) begin
            pc_d         = pc_q + 64'(INST_BYTES);
            inst_valid_d = 1'b0;
            state_d      = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        FLT: begin
          fault_d      = 1'b1;
          inst_valid_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      FETCH:   MEM_ADDR = pc_q + {62'd0, cnt_q};
      HOLD:    MEM_ADDR = pc_q;
      FLT:     MEM_ADDR = pc_q;
      default: MEM_ADDR = pc_q;
    endcase
  end

  assign INSTRUCTION = instruction_q;
  assign INST_PC     = inst_pc_q;
  assign INST_VALID  = inst_valid_q;
  assign FAULT       = fault_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Bench for ifetch_seq: directed vector table, hand sequences for redirect,
// end-of-memory and reset corners, then random traffic against a word-level model.
module tb_ifetch_seq;

  logic        CLK;
  logic        RST;
  logic [63:0] PC_IN;
  logic        PC_LOAD;
  logic [63:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic [31:0] INSTRUCTION;
  logic [63:0] INST_PC;
  logic        INST_VALID;
  logic        INST_READY;
  logic        FAULT;

  logic [7:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  ifetch_seq #(.MEM_BYTES(32), .RESET_PC(64'd0)) dut (
    .CLK(CLK), .RST(RST), .PC_IN(PC_IN), .PC_LOAD(PC_LOAD),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .INSTRUCTION(INSTRUCTION),
    .INST_PC(INST_PC), .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .FAULT(FAULT)
  );

  assign MEM_DATA = (MEM_ADDR < 64'd32) ? mem[MEM_ADDR[4:0]] : 8'h00;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst;
    logic        load;
    logic [63:0] pc_in;
    logic        ready;
    logic        valid;
    logic [31:0] inst;
    logic [63:0] ipc;
    logic        fault;
    logic [63:0] addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic l, input logic [63:0] p, input logic rd,
                     input logic v, input logic [31:0] ins, input logic [63:0] ipc,
                     input logic f, input logic [63:0] a);
    vec_t e;
    e.rst = r; e.load = l; e.pc_in = p; e.ready = rd;
    e.valid = v; e.inst = ins; e.ipc = ipc; e.fault = f; e.addr = a;
    tbl.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [63:0] p, input logic rd);
    RST = r; PC_LOAD = l; PC_IN = p; INST_READY = rd;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic v, input logic [31:0] ins,
                     input logic [63:0] ipc, input logic f, input logic [63:0] a,
                     input logic word);
    cmp({name, ".valid"}, {63'd0, INST_VALID}, {63'd0, v});
    cmp({name, ".fault"}, {63'd0, FAULT}, {63'd0, f});
    cmp({name, ".addr"}, MEM_ADDR, a);
    if (word) begin
      cmp({name, ".inst"}, {32'd0, INSTRUCTION}, {32'd0, ins});
      cmp({name, ".ipc"}, INST_PC, ipc);
    end
  endtask

  // Word-level reference model: what decode should see, from the fetch rules.
  logic [63:0] m_pc;
  int          m_left;
  logic        m_valid, m_fault, m_halted;
  logic [31:0] m_word;
  logic [63:0] m_ipc;

  function automatic logic [31:0] word_at(input logic [63:0] p);
    return {mem[p[4:0] + 5'd3], mem[p[4:0] + 5'd2], mem[p[4:0] + 5'd1], mem[p[4:0]]};
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic [63:0] p, input logic rd);
    if (r) begin
      m_pc = 64'd0; m_left = 4; m_valid = 1'b0; m_fault = 1'b0; m_halted = 1'b0;
      m_word = 32'd0; m_ipc = 64'd0;
    end else if (l) begin
      m_valid = 1'b0;
      if (p % 4 != 0) begin
        m_fault = 1'b1; m_halted = 1'b1;
      end else begin
        m_pc = p; m_left = 4; m_fault = 1'b0; m_halted = 1'b0;
      end
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0; m_pc = m_pc + 64'd4; m_left = 4;
      end
    end else if (m_left == 4 && m_pc > 64'd28) begin
      m_halted = 1'b1; m_fault = 1'b1;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1; m_word = word_at(m_pc); m_ipc = m_pc;
      end
    end
  endtask

  function automatic logic [63:0] model_addr();
    if (!m_halted && !m_valid) return m_pc + 64'(4 - m_left);
    return m_pc;
  endfunction

  initial begin
    RST = 1'b1; PC_LOAD = 1'b0; PC_IN = 64'd0; INST_READY = 1'b0;
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    for (int i = 4; i < 32; i++) mem[i] = 8'(8'h40 + i);

    // reset, first fetch, backpressure, streaming, mid-fetch and misaligned redirects
    add(1, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h0);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h1);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h2);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h3);
    add(0, 0, 64'h0, 0,  1, 32'h12345678, 64'h0, 0, 64'h0);
    add(0, 0, 64'h0, 0,  1, 32'h12345678, 64'h0, 0, 64'h0);
    add(0, 0, 64'h0, 0,  1, 32'h12345678, 64'h0, 0, 64'h0);
    add(0, 0, 64'h0, 0,  1, 32'h12345678, 64'h0, 0, 64'h0);
    add(0, 0, 64'h0, 1,  0, 32'h0, 64'h0, 0, 64'h4);
    add(0, 0, 64'h0, 1,  0, 32'h0, 64'h0, 0, 64'h5);
    add(0, 0, 64'h0, 1,  0, 32'h0, 64'h0, 0, 64'h6);
    add(0, 0, 64'h0, 1,  0, 32'h0, 64'h0, 0, 64'h7);
    add(0, 0, 64'h0, 1,  1, 32'h47464544, 64'h4, 0, 64'h4);
    add(0, 0, 64'h0, 1,  0, 32'h0, 64'h0, 0, 64'h8);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h9);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'hA);
    add(0, 1, 64'h10, 0, 0, 32'h0, 64'h0, 0, 64'h10);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h11);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h12);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h13);
    add(0, 0, 64'h0, 0,  1, 32'h53525150, 64'h10, 0, 64'h10);
    add(0, 1, 64'h6, 0,  0, 32'h0, 64'h0, 1, 64'h10);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 1, 64'h10);
    add(0, 1, 64'h8, 0,  0, 32'h0, 64'h0, 0, 64'h8);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'h9);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'hA);
    add(0, 0, 64'h0, 0,  0, 32'h0, 64'h0, 0, 64'hB);
    add(0, 0, 64'h0, 0,  1, 32'h4B4A4948, 64'h8, 0, 64'h8);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].load, tbl[i].pc_in, tbl[i].ready);
      chk($sformatf("vec%0d", i), tbl[i].valid, tbl[i].inst, tbl[i].ipc, tbl[i].fault,
          tbl[i].addr, tbl[i].valid | tbl[i].rst);
    end

    // redirect coinciding with handshake: next word from 0x14, not 0xC
    step(0, 1, 64'h14, 1); chk("hs_redir", 0, 32'h0, 64'h0, 0, 64'h14, 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 64'h0, 0); chk("hs_fetch", 0, 32'h0, 64'h0, 0, 64'h14 + 64'(i), 0);
    end
    step(0, 0, 64'h0, 0); chk("hs_word", 1, 32'h57565554, 64'h14, 0, 64'h14, 1);

    // last word of memory, then the range fault
    step(0, 1, 64'd28, 0); chk("eom_load", 0, 32'h0, 64'h0, 0, 64'd28, 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 64'h0, 0); chk("eom_fetch", 0, 32'h0, 64'h0, 0, 64'd28 + 64'(i), 0);
    end
    step(0, 0, 64'h0, 0); chk("eom_word", 1, 32'h5F5E5D5C, 64'd28, 0, 64'd28, 1);
    step(0, 0, 64'h0, 1); chk("eom_hs", 0, 32'h0, 64'h0, 0, 64'd32, 0);
    step(0, 0, 64'h0, 1); chk("eom_fault", 0, 32'h0, 64'h0, 1, 64'd32, 0);
    step(0, 0, 64'h0, 1); chk("eom_stay", 0, 32'h0, 64'h0, 1, 64'd32, 0);

    // pc near 2^64 must fault rather than wrap
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    chk("wrap_load", 0, 32'h0, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(0, 0, 64'h0, 0);
    chk("wrap_fault", 0, 32'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);

    // reset while holding a valid word
    step(0, 1, 64'h4, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 64'h0, 0);
    chk("rst_pre", 1, 32'h47464544, 64'h4, 0, 64'h4, 1);
    step(1, 0, 64'h0, 1); chk("rst_mid", 0, 32'h0, 64'h0, 0, 64'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 64'h0, 1);
    chk("rst_refetch", 1, 32'h12345678, 64'h0, 0, 64'h0, 1);

    // random traffic against the model
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    model_edge(1'b1, 1'b0, 64'h0, 1'b0);
    step(1, 0, 64'h0, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r, l, rd;
      logic [63:0] p;
      int          k;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 11) == 0);
      rd = $urandom_range(0, 1) == 1;
      k  = $urandom_range(0, 15);
      if (k < 10)       p = 64'($urandom_range(0, 8) * 4);
      else if (k < 12)  p = 64'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else if (k == 12) p = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
      else              p = 64'($urandom_range(0, 7) * 4);
      model_edge(r, l, p, rd);
      step(r, l, p, rd);
      chk("rand", m_valid, m_word, m_ipc, m_fault, model_addr(), m_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
